// File: rtl/cu_dmem_if.sv
// Data-memory request/response bus between compute_unit_top and cu_dmem_slave.
interface cu_dmem_if;
    logic        req_valid;
    logic        req_is_load;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        req_ready;
    logic        resp_valid;
    logic [4:0]  resp_rd;
    logic [31:0] resp_data;
    logic        resp_ready;

    modport master (
        output req_valid, req_is_load, req_addr, req_wdata, req_rd, resp_ready,
        input  req_ready, resp_valid, resp_rd, resp_data
    );

    modport slave (
        input  req_valid, req_is_load, req_addr, req_wdata, req_rd, resp_ready,
        output req_ready, resp_valid, resp_rd, resp_data
    );
endinterface

// File: rtl/cu_dmem_slave.sv
// On-chip data-memory slave: word SRAM, fixed-latency loads, credit-protected in-order response FIFO.
// Optional feature: define BOUNDS_CHECK_EN to trap out-of-range accesses (err_oob, 32'hDEAD_BEEF data).
module cu_dmem_slave #(
    parameter int          MEM_WORDS  = 4096,
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_F800,
    parameter int          READ_LAT   = 1,
    parameter int          RESP_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    cu_dmem_if.slave    bus,
    output logic        err_oob,
    output logic [31:0] load_cnt,
    output logic [31:0] store_cnt
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int PW = $clog2(RESP_DEPTH);

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } entry_t;

    logic [31:0]   mem_q  [MEM_WORDS];
    entry_t        fifo_q [RESP_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   fifo_cnt_q, fifo_cnt_d;
    logic [PW:0]   out_cnt_q, out_cnt_d;
    logic [31:0]   load_cnt_q, store_cnt_q;

    logic [32:0]   diff;
    logic [AW-1:0] idx;
    logic          oob;
    logic          req_acc, load_acc, store_acc;
    logic          push, pop;
    logic [31:0]   load_word;
    entry_t        push_entry;

    assign diff = {1'b0, bus.req_addr} - {1'b0, BASE_ADDR};
    assign idx  = diff[AW+1:2];

`ifdef BOUNDS_CHECK_EN
    // Borrow out of the subtraction means the address lies below BASE_ADDR.
    assign oob = diff[32] || (diff[31:AW+2] != '0);
    logic unused_lsb;
    assign unused_lsb = ^diff[1:0];

    logic err_q;
    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= req_acc && oob;
    end
    assign err_oob = err_q;
`else
    assign oob = 1'b0;
    logic unused_bits;
    assign unused_bits = ^{diff[32:AW+2], diff[1:0]};
    assign err_oob = 1'b0;
`endif

    // Every accepted load owns a FIFO slot from accept until pop, so capping
    // outstanding loads at RESP_DEPTH makes overflow impossible.
    assign bus.req_ready = !rst && (out_cnt_q < (PW+1)'(RESP_DEPTH));
    assign req_acc       = bus.req_valid && bus.req_ready;
    assign load_acc      = req_acc && bus.req_is_load;
    assign store_acc     = req_acc && !bus.req_is_load;
    assign load_word     = oob ? 32'hDEAD_BEEF : mem_q[idx];

    assign bus.resp_valid = (fifo_cnt_q != '0);
    assign bus.resp_rd    = bus.resp_valid ? fifo_q[rd_ptr_q].rd   : '0;
    assign bus.resp_data  = bus.resp_valid ? fifo_q[rd_ptr_q].data : '0;
    assign pop            = bus.resp_valid && bus.resp_ready;

    // NOTE: the SRAM array and FIFO payload carry no reset; only pointers, counts and valids do.
    always_ff @(posedge clk) begin
        if (store_acc && !oob) mem_q[idx] <= bus.req_wdata;
    end

    generate
        if (READ_LAT == 1) begin : g_direct
            assign push       = load_acc;
            assign push_entry = '{rd: bus.req_rd, data: load_word};
        end else begin : g_pipe
            localparam int P = READ_LAT - 1;
            logic [P-1:0] vld_q;
            entry_t       stage_q [P];

            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_q <= '0;
                end else begin
                    vld_q[0] <= load_acc;
                    for (int i = 1; i < P; i++) vld_q[i] <= vld_q[i-1];
                end
            end

            always_ff @(posedge clk) begin
                stage_q[0] <= '{rd: bus.req_rd, data: load_word};
                for (int i = 1; i < P; i++) stage_q[i] <= stage_q[i-1];
            end

            assign push       = vld_q[P-1];
            assign push_entry = stage_q[P-1];
        end
    endgenerate

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        out_cnt_d  = out_cnt_q;
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
            default: ;
        endcase
        case ({load_acc, pop})
            2'b10:   out_cnt_d = out_cnt_q + 1'b1;
            2'b01:   out_cnt_d = out_cnt_q - 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
            out_cnt_q   <= '0;
            load_cnt_q  <= '0;
            store_cnt_q <= '0;
        end else begin
            if (push)      wr_ptr_q    <= wr_ptr_q + 1'b1;
            if (pop)       rd_ptr_q    <= rd_ptr_q + 1'b1;
            if (load_acc)  load_cnt_q  <= load_cnt_q + 1'b1;
            if (store_acc) store_cnt_q <= store_cnt_q + 1'b1;
            fifo_cnt_q <= fifo_cnt_d;
            out_cnt_q  <= out_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= push_entry;
    end

    assign load_cnt  = load_cnt_q;
    assign store_cnt = store_cnt_q;
endmodule

// File: tb/tb_cu_dmem_slave.sv
// Directed bench for cu_dmem_slave: vector table plus hand sequences for credits, stalls, reset and wrap/OOB.
module tb_cu_dmem_slave;
    localparam logic [31:0] BASE = 32'hFFFF_F800;
    localparam int          LAT  = 1;
`ifdef BOUNDS_CHECK_EN
    localparam logic [31:0] HI_EXP  = 32'hDEAD_BEEF;
    localparam logic [31:0] OOB_EXP = 32'hDEAD_BEEF;
    localparam logic [31:0] ERR_EXP = 32'd1;
`else
    localparam logic [31:0] HI_EXP  = 32'h1234_5678;
    localparam logic [31:0] OOB_EXP = 32'hA5A5_0200;
    localparam logic [31:0] ERR_EXP = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        err_oob;
    logic [31:0] load_cnt, store_cnt;

    cu_dmem_if bus();

    cu_dmem_slave #(
        .MEM_WORDS (4096),
        .BASE_ADDR (BASE),
        .READ_LAT  (LAT),
        .RESP_DEPTH(16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .err_oob  (err_oob),
        .load_cnt (load_cnt),
        .store_cnt(store_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          cyc;
    } resp_t;

    typedef struct {
        logic        ld;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    resp_t got_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    cyc = 0;
    int    exp_loads = 0;
    int    exp_stores = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Response monitor: collects popped responses and checks hold-stability while stalled.
    logic        stall_prev = 1'b0;
    logic [4:0]  stall_rd;
    logic [31:0] stall_data;
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", 32'(bus.resp_valid), 32'd1);
                check("stall_rd",    32'(bus.resp_rd),    32'(stall_rd));
                check("stall_data",  bus.resp_data,       stall_data);
            end
            if (bus.resp_valid && bus.resp_ready)
                got_q.push_back('{rd: bus.resp_rd, data: bus.resp_data, cyc: cyc});
            stall_prev = bus.resp_valid && !bus.resp_ready;
            stall_rd   = bus.resp_rd;
            stall_data = bus.resp_data;
        end
    end

    // Called and returns just after a rising edge; holds the request until accepted.
    task automatic send(input logic ld, input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        bus.req_valid = 1'b1; bus.req_is_load = ld; bus.req_addr = a;
        bus.req_wdata = wd;   bus.req_rd = rd;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = bus.req_ready;
            @(posedge clk); #1;
            n++;
        end
        bus.req_valid = 1'b0;
        if (!acc) check("send_accept", 32'(acc), 32'd1);
        else if (ld) exp_loads++;
        else exp_stores++;
    endtask

    task automatic wait_resp(input int n);
        int k;
        k = 0;
        while (got_q.size() < n && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        repeat (3) begin @(posedge clk); #1; end
        check("resp_count", 32'(got_q.size()), 32'(n));
    endtask

    task automatic expect_resp(input string name, input logic [4:0] rd, input logic [31:0] d);
        resp_t r;
        if (got_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got no response, expected rd=%0d data=%h", name, rd, d);
        end else begin
            r = got_q.pop_front();
            check({name, "_rd"},   32'(r.rd), 32'(rd));
            check({name, "_data"}, r.data,    d);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  vt[14];
        resp_t r;
        int    prev_cyc;
        int    nacc;
        logic  a;

        bus.req_valid = 1'b0; bus.req_is_load = 1'b0; bus.req_addr = '0;
        bus.req_wdata = '0;   bus.req_rd = '0;        bus.resp_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready_after", 32'(bus.req_ready),  32'd1);
        check("rst_resp_valid",  32'(bus.resp_valid), 32'd0);
        check("rst_resp_rd",     32'(bus.resp_rd),    32'd0);
        check("rst_resp_data",   bus.resp_data,       32'd0);
        check("rst_err_oob",     32'(err_oob),        32'd0);
        check("rst_load_cnt",    load_cnt,            32'd0);
        check("rst_store_cnt",   store_cnt,           32'd0);
        @(posedge clk); #1;

        // Store then load next cycle: exact latency
        send(1'b0, BASE, 32'd12, 5'd0);
        bus.req_valid = 1'b1; bus.req_is_load = 1'b1; bus.req_addr = BASE; bus.req_rd = 5'd5;
        @(negedge clk);
        check("t1_ready",     32'(bus.req_ready),  32'd1);
        check("t1_pre_valid", 32'(bus.resp_valid), 32'd0);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        exp_loads++;
        repeat (LAT-1) begin @(posedge clk); #1; end
        @(negedge clk);
        check("t1_valid", 32'(bus.resp_valid), 32'd1);
        check("t1_rd",    32'(bus.resp_rd),    32'd5);
        check("t1_data",  bus.resp_data,       32'd12);
        @(posedge clk); #1;
        got_q.delete();

        // Vector table
        vt[0]  = '{1'b0, BASE + 32'd16,  32'd1,          5'd0,  32'd0};
        vt[1]  = '{1'b0, BASE + 32'd20,  32'd2,          5'd0,  32'd0};
        vt[2]  = '{1'b0, BASE + 32'd24,  32'd3,          5'd0,  32'd0};
        vt[3]  = '{1'b0, BASE + 32'd28,  32'd4,          5'd0,  32'd0};
        vt[4]  = '{1'b1, BASE + 32'd16,  32'd0,          5'd1,  32'd1};
        vt[5]  = '{1'b1, BASE + 32'd20,  32'd0,          5'd2,  32'd2};
        vt[6]  = '{1'b1, BASE + 32'd24,  32'd0,          5'd3,  32'd3};
        vt[7]  = '{1'b1, BASE + 32'd28,  32'd0,          5'd4,  32'd4};
        vt[8]  = '{1'b0, BASE + 32'h3FFC, 32'h1234_5678, 5'd0,  32'd0};
        vt[9]  = '{1'b0, 32'hFFFF_FFFC,  32'h0BAD_F00D,  5'd0,  32'd0};
        vt[10] = '{1'b1, BASE + 32'h3FFD, 32'd0,         5'd10, HI_EXP};
        vt[11] = '{1'b0, BASE + 32'd16,  32'h55,         5'd0,  32'd0};
        vt[12] = '{1'b1, BASE + 32'd16,  32'd0,          5'd12, 32'h55};
        vt[13] = '{1'b1, 32'hFFFF_FFFF,  32'd0,          5'd31, 32'h0BAD_F00D};
        for (int i = 0; i < 14; i++) send(vt[i].ld, vt[i].addr, vt[i].wdata, vt[i].rd);
        wait_resp(7);
        prev_cyc = 0;
        for (int i = 0; i < 14; i++) begin
            if (vt[i].ld) begin
                if (i >= 5 && i <= 7 && got_q.size() > 0)
                    check("vec_back_to_back", 32'(got_q[0].cyc - prev_cyc), 32'd1);
                if (got_q.size() > 0) prev_cyc = got_q[0].cyc;
                expect_resp($sformatf("vec%0d", i), vt[i].rd, vt[i].exp);
            end
        end
        check("vec_load_cnt",  load_cnt,  32'(exp_loads));
        check("vec_store_cnt", store_cnt, 32'(exp_stores));

        // Credit backpressure: 20 loads against a stalled consumer
        for (int i = 0; i < 20; i++) send(1'b0, BASE + 32'h100 + 32'(4*i), 32'(100 + 3*i), 5'd0);
        bus.resp_ready = 1'b0;
        nacc = 0;
        for (int c = 0; c < 30 && nacc < 20; c++) begin
            bus.req_valid = 1'b1; bus.req_is_load = 1'b1;
            bus.req_addr = BASE + 32'h100 + 32'(4*nacc); bus.req_rd = nacc[4:0];
            @(negedge clk);
            a = bus.req_ready;
            @(posedge clk); #1;
            if (a) nacc++;
        end
        check("bp_accepted", 32'(nacc), 32'd16);
        exp_loads += nacc;
        @(negedge clk);
        check("bp_full_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk); #1;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_before_pop", 32'(bus.req_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_ready_after_pop", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        nacc++;
        exp_loads++;
        for (int i = nacc; i < 20; i++) send(1'b1, BASE + 32'h100 + 32'(4*i), 32'd0, 5'(i));
        wait_resp(20);
        for (int i = 0; i < 20; i++) expect_resp($sformatf("bp%0d", i), 5'(i), 32'(100 + 3*i));

        // Consumer toggling ready every cycle during a load stream
        fork
            begin
                for (int i = 0; i < 10; i++) send(1'b1, BASE + 32'h100 + 32'(4*i), 32'd0, 5'(i + 1));
            end
            begin
                for (int c = 0; c < 40; c++) begin
                    @(posedge clk); #1;
                    bus.resp_ready = ~bus.resp_ready;
                end
                bus.resp_ready = 1'b1;
            end
        join
        wait_resp(10);
        check("tog_load_cnt", load_cnt, 32'(exp_loads));
        for (int i = 0; i < 10; i++) expect_resp($sformatf("tog%0d", i), 5'(i + 1), 32'(100 + 3*i));

        // Reset with three loads in flight
        send(1'b0, BASE + 32'h40, 32'hCAFE_0001, 5'd0);
        bus.resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(1'b1, BASE + 32'h40, 32'd0, 5'(20 + i));
        @(negedge clk);
        check("rst2_inflight", 32'(bus.resp_valid), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst2_ready_low", 32'(bus.req_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.resp_ready = 1'b1;
        exp_loads = 0;
        exp_stores = 0;
        got_q.delete();
        @(negedge clk);
        check("rst2_valid",     32'(bus.resp_valid), 32'd0);
        check("rst2_load_cnt",  load_cnt,            32'd0);
        check("rst2_store_cnt", store_cnt,           32'd0);
        check("rst2_ready",     32'(bus.req_ready),  32'd1);
        repeat (5) begin @(posedge clk); #1; end
        check("rst2_no_resp", 32'(got_q.size()), 32'd0);
        send(1'b1, BASE + 32'h40, 32'd0, 5'd6);
        wait_resp(1);
        expect_resp("rst2_sram_kept", 5'd6, 32'hCAFE_0001);

        // Load at 0x0000_0000: wrapped word or out-of-bounds trap
        send(1'b0, 32'h0000_4000, 32'hA5A5_0200, 5'd0);
        send(1'b1, 32'h0000_0000, 32'd0, 5'd9);
        @(negedge clk);
        check("oob_err_pulse", 32'(err_oob), ERR_EXP);
        @(posedge clk); #1;
        @(negedge clk);
        check("oob_err_clear", 32'(err_oob), 32'd0);
        @(posedge clk); #1;
        wait_resp(1);
        expect_resp("oob_load", 5'd9, OOB_EXP);

        check("end_load_cnt",  load_cnt,  32'(exp_loads));
        check("end_store_cnt", store_cnt, 32'(exp_stores));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
